// File: rtl/serial_operand_recover_pkg.sv
// Shared types and sizing for the bit-serial operand recovery block.
package serial_operand_recover_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Default addend width and the matching bit-counter width (counts 0..WIDTH).
  localparam int DEF_WIDTH = 4;
  localparam int CNT_W     = $clog2(DEF_WIDTH + 2);

  // Counter width for an arbitrary addend width.
  function automatic int cnt_bits(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = s - a - bin, bout set on underflow.
module full_subtractor_bit (
  input  logic s,
  input  logic a,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out for a single bit position.
  always_comb begin
    d    = s ^ a ^ bin;
    bout = (~s & a) | (~(s ^ a) & bin);
  end

endmodule

// File: rtl/serial_operand_recover.sv
// Recovers addend b = sum - a by LSB-first bit-serial subtraction, one bit
// per clock, with valid/ready handshakes on both sides.
module serial_operand_recover
  import serial_operand_recover_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum_in,
  input  logic [WIDTH-1:0] a_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] b_out,
  output logic             err
);

  localparam int CW = (WIDTH == DEF_WIDTH) ? CNT_W : cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);

  state_t           state_reg;
  logic [WIDTH:0]   sum_sh_reg;
  logic [WIDTH:0]   a_sh_reg;
  logic [WIDTH-1:0] res_reg;
  logic             borrow_reg;
  logic             primed_reg;
  logic [CW-1:0]    cnt_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] b_out_reg;
  logic             err_reg;

  logic             d_bit;
  logic             borrow_next;
  logic [WIDTH:0]   diff_next;

  full_subtractor_bit u_fsb (
    .s    (sum_sh_reg[0]),
    .a    (a_sh_reg[0]),
    .bin  (borrow_reg),
    .d    (d_bit),
    .bout (borrow_next)
  );

  // Result bits collected so far sit in res_reg; the current bit lands on top,
  // so on the last bit cycle diff_next is the complete WIDTH+1 bit difference.
  assign diff_next = {d_bit, res_reg};

  // Control FSM with shift datapath and registered handshake/result outputs.
  // The first SHIFT cycle after capture is an alignment cycle (primed_reg=0);
  // the following WIDTH+1 cycles each resolve one difference bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      sum_sh_reg    <= '0;
      a_sh_reg      <= '0;
      res_reg       <= '0;
      borrow_reg    <= 1'b0;
      primed_reg    <= 1'b0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      b_out_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            sum_sh_reg   <= sum_in;
            a_sh_reg     <= {1'b0, a_in};
            res_reg      <= '0;
            borrow_reg   <= 1'b0;
            primed_reg   <= 1'b0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          if (!primed_reg) begin
            primed_reg <= 1'b1;
          end else begin
            sum_sh_reg <= sum_sh_reg >> 1;
            a_sh_reg   <= a_sh_reg >> 1;
            borrow_reg <= borrow_next;
            res_reg    <= diff_next[WIDTH:1];
            cnt_reg    <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_BIT) begin
              // Negative (final borrow) or too large for WIDTH bits.
              b_out_reg     <= diff_next[WIDTH-1:0];
              err_reg       <= borrow_next | diff_next[WIDTH];
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign b_out     = b_out_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_serial_operand_recover.sv
// Directed bench for serial_operand_recover (WIDTH=4).
module tb_serial_operand_recover;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] sum_in;
  logic [3:0] a_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] b_out;
  logic       err;

  int errors = 0;
  int checks = 0;

  serial_operand_recover #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .a_in      (a_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b_out     (b_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present one operand pair and complete the input handshake.
  task automatic start_op(input logic [4:0] s, input logic [3:0] a);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    sum_in   = s;
    a_in     = a;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("in_ready_busy", in_ready, 0);
  endtask

  // Wait (bounded) for out_valid and check latency and result.
  task automatic wait_result(input logic [4:0] s, input logic [3:0] a,
                             input logic [3:0] eb, input logic ee);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", lat, 6);
    check("b_out", b_out, eb);
    check("err", err, ee);
    $display("op sum=%0d a=%0d -> b=%0d err=%0d latency=%0d", s, a, b_out, err, lat);
  endtask

  // Full transaction with out_ready held high: out_valid lasts one cycle.
  task automatic run_op(input logic [4:0] s, input logic [3:0] a,
                        input logic [3:0] eb, input logic ee);
    start_op(s, a);
    wait_result(s, a, eb, ee);
    @(posedge clk);
    #1;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    sum_in    = '0;
    a_in      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_b_out", b_out, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic, max legal, negative, overflow.
    run_op(5'd13, 4'd5, 4'd8, 1'b0);
    run_op(5'd30, 4'd15, 4'd15, 1'b0);
    run_op(5'd3, 4'd7, 4'hC, 1'b1);
    run_op(5'd31, 4'd0, 4'hF, 1'b1);

    // Back-pressure: result held while out_ready low, new input ignored.
    out_ready = 1'b0;
    start_op(5'd13, 4'd5);
    wait_result(5'd13, 4'd5, 4'd8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sum_in   = 5'd31;
      a_in     = 4'd0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_b_out", b_out, 8);
      check("hold_err", err, 0);
      check("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("idle_no_op", out_valid, 0);
    end
    check("idle_b_kept", b_out, 8);

    // Reset during the third SHIFT cycle abandons the operation.
    start_op(5'd13, 4'd5);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_b_out", b_out, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_in_ready", in_ready, 1);
    #2;
    rst = 1'b0;
    run_op(5'd9, 4'd4, 4'd5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
